// File: rtl/lut_eval_filtered.sv
// lut_eval_filtered
//   Runtime-loadable N-input truth-table evaluator with a settle filter that
//   models slow gate response. The active table is replaced through a serial
//   bit-by-bit load (LSB first) and swapped in atomically on commit.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_bits     logic inputs; in_bits[N_IN-1] is the table index MSB
//   cfg_start   begin or restart a table load
//   cfg_valid   cfg_bit is valid this cycle
//   cfg_bit     serial table bit, index 0 first
//   cfg_ready   high while loading; a bit transfers on cfg_valid && cfg_ready
//   cfg_done    one-cycle pulse while the new table is being committed
//   tt_active   currently active truth table
//   out_raw     registered tt_active[in_bits]
//   out         settle-filtered out_raw
//   out_toggle  one-cycle pulse on the cycle out changes
module lut_eval_filtered #(
  parameter int unsigned               N_IN       = 3,
  parameter int unsigned               SETTLE     = 4,
  parameter logic [(2**N_IN)-1:0]      DEFAULT_TT = 8'hE8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN-1:0]        in_bits,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  input  logic                   cfg_bit,
  output logic                   cfg_ready,
  output logic                   cfg_done,
  output logic [(2**N_IN)-1:0]   tt_active,
  output logic                   out_raw,
  output logic                   out,
  output logic                   out_toggle
);

  localparam int unsigned TT_W = 2**N_IN;
  localparam int unsigned CW   = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t            state_q;
  logic [N_IN-1:0]   idx_q;
  logic [TT_W-1:0]   shadow_q;
  logic [TT_W-1:0]   tt_q;
  logic              ready_q;
  logic              done_q;

  logic              raw_q, raw_d;
  logic              out_q, out_d;
  logic              tog_q, tog_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Load FSM: bits accumulate in a shadow register so evaluation keeps using
  // the old table until the whole new one has arrived.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      tt_q     <= DEFAULT_TT;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            state_q  <= LOAD;
            idx_q    <= '0;
            shadow_q <= '0;
            ready_q  <= 1'b1;
          end
        end
        LOAD: begin
          // Restart wins over a simultaneous bit, which is dropped.
          if (cfg_start) begin
            idx_q    <= '0;
            shadow_q <= '0;
          end else if (cfg_valid) begin
            shadow_q[idx_q] <= cfg_bit;
            idx_q           <= idx_q + 1'b1;
            if (idx_q == N_IN'(TT_W - 1)) begin
              state_q <= COMMIT;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        COMMIT: begin
          tt_q    <= shadow_q;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Settle filter: out only follows out_raw after SETTLE consecutive
  // mismatching cycles; any agreement in between clears the count.
  always_comb begin
    raw_d = tt_q[in_bits];
    out_d = out_q;
    tog_d = 1'b0;
    cnt_d = cnt_q;
    if (raw_q == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(SETTLE - 1)) begin
      out_d = raw_q;
      tog_d = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q <= 1'b0;
      out_q <= 1'b0;
      tog_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      raw_q <= raw_d;
      out_q <= out_d;
      tog_q <= tog_d;
      cnt_q <= cnt_d;
    end
  end

  assign cfg_ready  = ready_q;
  assign cfg_done   = done_q;
  assign tt_active  = tt_q;
  assign out_raw    = raw_q;
  assign out        = out_q;
  assign out_toggle = tog_q;

endmodule

// File: tb/tb_lut_eval_filtered.sv
module tb_lut_eval_filtered;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_bits;
  logic       cfg_start, cfg_valid, cfg_bit;
  logic       cfg_ready, cfg_done, out_raw, out, out_toggle;
  logic [7:0] tt_active;

  lut_eval_filtered #(.N_IN(3), .SETTLE(4), .DEFAULT_TT(8'hE8)) dut (
    .clk(clk), .rst(rst), .in_bits(in_bits),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .tt_active(tt_active),
    .out_raw(out_raw), .out(out), .out_toggle(out_toggle)
  );

  always #5 clk = ~clk;

  // Field codes for scoreboard entries
  localparam int F_RAW = 0, F_OUT = 1, F_TOG = 2, F_RDY = 3, F_DONE = 4, F_TT = 5, F_NDONE = 6;

  typedef struct {
    int         cyc;
    int         fld;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   ndone  = 0;
  int   total  = 0;
  int   bad    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fname(input int f);
    case (f)
      F_RAW:  return "out_raw";
      F_OUT:  return "out";
      F_TOG:  return "out_toggle";
      F_RDY:  return "cfg_ready";
      F_DONE: return "cfg_done";
      F_TT:   return "tt_active";
      default: return "done_count";
    endcase
  endfunction

  function automatic logic [7:0] actual(input int f);
    case (f)
      F_RAW:  return {7'd0, out_raw};
      F_OUT:  return {7'd0, out};
      F_TOG:  return {7'd0, out_toggle};
      F_RDY:  return {7'd0, cfg_ready};
      F_DONE: return {7'd0, cfg_done};
      F_TT:   return tt_active;
      default: return ndone[7:0];
    endcase
  endfunction

  // Queue an expectation for the negedge 'at' posedges from now.
  task automatic expect_at(input int at, input int f, input logic [7:0] v);
    exp_t e;
    e.cyc = cyc + at;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endtask

  // Monitor: compares every due entry at the falling edge.
  always @(negedge clk) begin
    if (cfg_done === 1'b1) ndone = ndone + 1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        total = total + 1;
        if (sb[i].cyc < cyc) begin
          bad = bad + 1;
          $display("FAIL %s @cyc%0d: check missed (now cyc%0d)", fname(sb[i].fld), sb[i].cyc, cyc);
        end else if (actual(sb[i].fld) !== sb[i].val) begin
          bad = bad + 1;
          $display("FAIL %s @cyc%0d: got %h want %h", fname(sb[i].fld), cyc, actual(sb[i].fld), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full 8-bit load with 1-2 cycle gaps between bits.
  task automatic load_full(input logic [7:0] v, input int exp_ndone);
    cfg_start = 1'b1;
    cycles(1);
    cfg_start = 1'b0;
    expect_at(0 + 1, F_RDY, 8'd1);
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = v[i];
      if (i < 7) begin
        expect_at(1, F_RDY, 8'd1);
        expect_at(1, F_DONE, 8'd0);
      end else begin
        expect_at(1, F_RDY, 8'd0);
        expect_at(1, F_DONE, 8'd1);
        expect_at(2, F_DONE, 8'd0);
        expect_at(2, F_TT, v);
        expect_at(3, F_NDONE, exp_ndone[7:0]);
      end
      cycles(1);
      cfg_valid = 1'b0;
      if (i < 7) cycles(1 + (i % 2));
    end
    cycles(4);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = v[i];
      cycles(1);
      cfg_valid = 1'b0;
      cycles(1);
    end
  endtask

  initial begin
    rst = 1'b1; in_bits = 3'b000;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    cycles(1);
    expect_at(1, F_TT, 8'hE8);
    expect_at(1, F_OUT, 8'd0);
    expect_at(1, F_RDY, 8'd0);
    cycles(2);
    rst = 1'b0;

    // Idle with in_bits = 000: out stays low, no toggle
    for (int i = 1; i <= 10; i++) begin
      expect_at(i, F_OUT, 8'd0);
      expect_at(i, F_TOG, 8'd0);
    end
    cycles(10);

    // Majority rise: 011 -> tt[3] = 1
    in_bits = 3'b011;
    expect_at(1, F_RAW, 8'd1);
    expect_at(4, F_OUT, 8'd0);
    expect_at(4, F_TOG, 8'd0);
    expect_at(5, F_OUT, 8'd1);
    expect_at(5, F_TOG, 8'd1);
    expect_at(6, F_TOG, 8'd0);
    cycles(8);

    // Majority fall: 100 -> tt[4] = 0
    in_bits = 3'b100;
    expect_at(1, F_RAW, 8'd0);
    expect_at(4, F_OUT, 8'd1);
    expect_at(5, F_OUT, 8'd0);
    expect_at(5, F_TOG, 8'd1);
    expect_at(6, F_TOG, 8'd0);
    cycles(8);

    // Glitch: 111 for 3 cycles, then back to 000
    in_bits = 3'b111;
    expect_at(1, F_RAW, 8'd1);
    expect_at(3, F_RAW, 8'd1);
    expect_at(4, F_RAW, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      expect_at(i, F_OUT, 8'd0);
      expect_at(i, F_TOG, 8'd0);
    end
    cycles(3);
    in_bits = 3'b000;
    cycles(8);

    // Drive out high, then assert reset mid-run (checked before next edge)
    in_bits = 3'b101;
    expect_at(6, F_OUT, 8'd1);
    cycles(7);
    @(posedge clk); #2;
    rst = 1'b1;
    expect_at(0, F_RAW, 8'd0);
    expect_at(0, F_OUT, 8'd0);
    expect_at(0, F_TOG, 8'd0);
    expect_at(0, F_TT, 8'hE8);
    cycles(2);
    rst = 1'b0;
    in_bits = 3'b000;
    cycles(8);

    // Load XOR-3 and evaluate it
    load_full(8'h96, 1);
    in_bits = 3'b011;
    expect_at(1, F_RAW, 8'd0);
    cycles(3);
    in_bits = 3'b111;
    expect_at(1, F_RAW, 8'd1);
    cycles(3);
    in_bits = 3'b000;
    cycles(8);

    // Restart after 5 bits; restart cycle also carries a dropped bit
    cfg_start = 1'b1;
    cycles(1);
    cfg_start = 1'b0;
    send_bits(8'hFF, 5);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
    expect_at(1, F_RDY, 8'd1);
    cycles(1);
    cfg_start = 1'b0; cfg_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = (i == 0);
      if (i == 7) begin
        expect_at(1, F_DONE, 8'd1);
        expect_at(2, F_TT, 8'h01);
      end
      cycles(1);
      cfg_valid = 1'b0;
      cycles(1);
    end
    expect_at(2, F_NDONE, 8'd2);
    cycles(4);

    // Reset mid-load after 3 bits
    cfg_start = 1'b1;
    cycles(1);
    cfg_start = 1'b0;
    send_bits(8'h00, 3);
    @(posedge clk); #2;
    rst = 1'b1;
    expect_at(0, F_RDY, 8'd0);
    expect_at(0, F_DONE, 8'd0);
    expect_at(0, F_TT, 8'hE8);
    cycles(2);
    rst = 1'b0;
    expect_at(3, F_NDONE, 8'd2);
    expect_at(3, F_TT, 8'hE8);
    cycles(5);
    load_full(8'hFF, 3);

    cycles(10);
    if (sb.size() != 0) begin
      total = total + sb.size();
      bad   = bad + sb.size();
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
